// File: rtl/spike_sched_pkg.sv
// Shared types and constants for the spike scheduler and its arbiter.
package spike_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DELAY   = 2'd1,
      ST_FIRE    = 2'd2,
      ST_REFRACT = 2'd3
   } state_t;

   localparam state_t RST_STATE = ST_IDLE;
   localparam logic   RST_SPIKE = 1'b0;

   // Source-index width; a single input still needs one bit.
   function automatic int unsigned src_w(input int unsigned n);
      return (n < 32'd2) ? 32'd1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spike_scheduler_rr_arbiter.sv
// Combinational round-robin search: first set request after last_grant, wrapping.
module rr_arbiter
   import spike_sched_pkg::*;
#(
   parameter  int unsigned N_IN  = 4,
   localparam int unsigned SRC_W = src_w(N_IN)
) (
   input  logic [N_IN-1:0]  req,
   input  logic [SRC_W-1:0] last_grant,
   output logic             grant_valid,
   output logic [SRC_W-1:0] grant_idx
);

   logic [N_IN-1:0] rot;

   // rot[j] is the request that sits j+1 places after last_grant.
   always_comb begin
      rot         = N_IN'({req, req} >> (int'(last_grant) + 1));
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int j = int'(N_IN) - 1; j >= 0; j--) begin
         if (rot[j]) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_W'((int'(last_grant) + 1 + j) % int'(N_IN));
         end
      end
   end

endmodule

// File: rtl/spike_scheduler.sv
// Shares one programmable-delay synapse channel among N_IN presynaptic inputs:
// edge-latched requests, round-robin grant, delay, one-cycle pulse, refractory gap.
module spike_scheduler
   import spike_sched_pkg::*;
#(
   parameter  int unsigned N_IN    = 4,
   parameter  int unsigned DLY_W   = 2,
   parameter  int unsigned REFRACT = 1,
   parameter  int unsigned CNT_W   = 8,
   localparam int unsigned SRC_W   = src_w(N_IN)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IN-1:0]  spike_in,
   input  logic [DLY_W-1:0] delay_cfg,
   input  logic             en,
   input  logic             clr_drop,
   output logic             spike_out,
   output logic [SRC_W-1:0] spike_src,
   output logic             busy,
   output logic [N_IN-1:0]  pending,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int unsigned REF_W   = (REFRACT < 2) ? 1 : $clog2(REFRACT);
   localparam int unsigned TMR_W   = (DLY_W > REF_W) ? DLY_W : REF_W;
   localparam int unsigned NDROP_W = SRC_W + 1;
   localparam int unsigned SUM_W   = CNT_W + 1;
   localparam logic [TMR_W-1:0] REF_LOAD = TMR_W'((REFRACT == 0) ? 0 : REFRACT - 1);
   localparam logic [SRC_W-1:0] RST_LAST = SRC_W'(N_IN - 1);

   state_t             state, state_next;
   logic [TMR_W-1:0]   tmr, tmr_next;
   logic [N_IN-1:0]    spike_q, rise, grant_vec, drop_vec, pending_next;
   logic [SRC_W-1:0]   last_grant, grant_idx;
   logic               grant_valid, take, spike_next, busy_next;
   logic [NDROP_W-1:0] ndrop;
   logic [SUM_W-1:0]   drop_sum;
   logic [CNT_W-1:0]   drop_next;

   rr_arbiter #(.N_IN(N_IN)) u_arb (
      .req         (pending),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // Request bookkeeping: a granted source that re-spikes keeps its new request.
   always_comb begin
      take         = (state == ST_IDLE) && en && grant_valid;
      grant_vec    = take ? (N_IN'(1) << grant_idx) : '0;
      rise         = spike_in & ~spike_q;
      drop_vec     = rise & pending & ~grant_vec;
      pending_next = (pending & ~grant_vec) | rise;
      ndrop        = '0;
      for (int i = 0; i < int'(N_IN); i++) begin
         ndrop = ndrop + NDROP_W'(drop_vec[i]);
      end
      drop_sum = SUM_W'(drop_cnt) + SUM_W'(ndrop);
      if (clr_drop) begin
         drop_next = '0;
      end else if (drop_sum[CNT_W]) begin
         drop_next = '1;
      end else begin
         drop_next = drop_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RST_STATE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:    if (take) state_next = ST_DELAY;
         ST_DELAY:   if (tmr == '0) state_next = ST_FIRE;
         ST_FIRE:    state_next = (REFRACT == 0) ? ST_IDLE : ST_REFRACT;
         ST_REFRACT: if (tmr == '0) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Timer reload/countdown and the registered-output next values.
   always_comb begin
      tmr_next   = tmr;
      spike_next = (state_next == ST_FIRE);
      busy_next  = (state_next != ST_IDLE);
      case (state)
         ST_IDLE:    if (take) tmr_next = TMR_W'(delay_cfg);
         ST_DELAY:   if (tmr != '0) tmr_next = tmr - TMR_W'(1);
         ST_FIRE:    tmr_next = REF_LOAD;
         ST_REFRACT: if (tmr != '0) tmr_next = tmr - TMR_W'(1);
         default:    tmr_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmr        <= '0;
         spike_q    <= '0;
         pending    <= '0;
         drop_cnt   <= '0;
         last_grant <= RST_LAST;
         spike_src  <= '0;
         spike_out  <= RST_SPIKE;
         busy       <= 1'b0;
      end else begin
         tmr       <= tmr_next;
         spike_q   <= spike_in;
         pending   <= pending_next;
         drop_cnt  <= drop_next;
         spike_out <= spike_next;
         busy      <= busy_next;
         if (take) begin
            last_grant <= grant_idx;
            spike_src  <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_spike_scheduler.sv
// Directed bench for spike_scheduler with a timeline-level reference model.
module tb_spike_scheduler;

   localparam int unsigned N_IN    = 4;
   localparam int unsigned DLY_W   = 2;
   localparam int unsigned REFRACT = 1;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned SRC_W   = 2;
   localparam int          DMAX    = (1 << CNT_W) - 1;

   logic             clk;
   logic             reset;
   logic [N_IN-1:0]  spike_in;
   logic [DLY_W-1:0] delay_cfg;
   logic             en;
   logic             clr_drop;
   logic             spike_out;
   logic [SRC_W-1:0] spike_src;
   logic             busy;
   logic [N_IN-1:0]  pending;
   logic [CNT_W-1:0] drop_cnt;

   int nvec = 0;
   int nerr = 0;

   // Model: edge index, and the edge numbers at which the channel fires / frees.
   int              t, free_at, fire_at, bstart, lastg, m_src, m_drop, m_gi;
   logic [N_IN-1:0] m_pend, m_prev, m_edge;

   logic             fair_on;
   logic [SRC_W-1:0] fires[$];
   int               pulses;

   spike_scheduler #(
      .N_IN(N_IN), .DLY_W(DLY_W), .REFRACT(REFRACT), .CNT_W(CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .spike_in  (spike_in),
      .delay_cfg (delay_cfg),
      .en        (en),
      .clr_drop  (clr_drop),
      .spike_out (spike_out),
      .spike_src (spike_src),
      .busy      (busy),
      .pending   (pending),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: requests, rotating priority, and grant-to-pulse timeline arithmetic.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         t = 0; free_at = 0; fire_at = -10; bstart = -10;
         lastg = N_IN - 1; m_src = 0; m_drop = 0;
         m_pend = '0; m_prev = '0;
      end else begin
         t++;
         m_edge = spike_in & ~m_prev;
         m_prev = spike_in;
         m_gi = -1;
         if (en && t >= free_at && m_pend != '0)
            for (int k = 1; k <= int'(N_IN); k++)
               if (m_gi < 0 && m_pend[(lastg + k) % N_IN]) m_gi = (lastg + k) % N_IN;
         for (int i = 0; i < int'(N_IN); i++)
            if (m_edge[i] && m_pend[i] && i != m_gi && m_drop < DMAX) m_drop++;
         if (clr_drop) m_drop = 0;
         if (m_gi >= 0) begin
            m_pend[m_gi] = 1'b0;
            lastg   = m_gi;
            m_src   = m_gi;
            bstart  = t;
            fire_at = t + int'(delay_cfg) + 1;
            free_at = t + int'(delay_cfg) + int'(REFRACT) + 3;
         end
         m_pend = m_pend | m_edge;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         chk("spike_out", 32'(spike_out), 32'(t == fire_at));
         chk("busy", 32'(busy), 32'(t >= bstart && t <= free_at - 2));
         chk("spike_src", 32'(spike_src), 32'(m_src));
         chk("pending", 32'(pending), 32'(m_pend));
         chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
         if (fair_on && spike_out === 1'b1) fires.push_back(spike_src);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; spike_in = '0; delay_cfg = '0; en = 1'b1; clr_drop = 1'b0;
      fair_on = 1'b0;
      #12;
      chk("rst_spike_out", 32'(spike_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_pending", 32'(pending), 0);
      chk("rst_drop", 32'(drop_cnt), 0);
      chk("rst_src", 32'(spike_src), 0);
      #10 reset = 1'b1;
      repeat (2) cyc();

      // Contention: src0 and src3 together, d=0.
      spike_in = 4'b1001; cyc();                  // E0
      chk("cont_pend_e0", 32'(pending), 32'h9);
      spike_in = '0; cyc();                       // E1
      chk("cont_src_e1", 32'(spike_src), 0);
      chk("cont_pend_e1", 32'(pending), 32'h8);
      cyc();                                      // E2
      chk("cont_fire0", 32'(spike_out), 1);
      cyc(); cyc();                               // E4
      chk("cont_idle_e4", 32'(busy), 0);
      cyc();                                      // E5
      chk("cont_src_e5", 32'(spike_src), 3);
      chk("cont_busy_e5", 32'(busy), 1);
      cyc();                                      // E6
      chk("cont_fire3", 32'(spike_out), 1);
      chk("cont_drop", 32'(drop_cnt), 0);
      repeat (3) cyc();

      // Single spike on src2, d=3.
      delay_cfg = 2'd3;
      spike_in = 4'b0100; cyc();                  // E0
      chk("single_pend_e0", 32'(pending), 32'h4);
      spike_in = '0; cyc();                       // E1
      chk("single_pend_e1", 32'(pending), 0);
      chk("single_busy_e1", 32'(busy), 1);
      chk("single_src_e1", 32'(spike_src), 2);
      for (int k = 2; k <= 4; k++) begin
         cyc();
         chk("single_early", 32'(spike_out), 0);
      end
      cyc();                                      // E5
      chk("single_fire", 32'(spike_out), 1);
      chk("single_src", 32'(spike_src), 2);
      cyc();                                      // E6
      chk("single_once", 32'(spike_out), 0);
      chk("single_busy_e6", 32'(busy), 1);
      cyc();                                      // E7
      chk("single_idle_e7", 32'(busy), 0);
      repeat (2) cyc();

      // Fairness: src1 and src2 re-pulsing continuously, d=0.
      delay_cfg = 2'd0;
      fair_on = 1'b1;
      for (int c = 0; c < 40; c++) begin
         spike_in = (c % 2 == 0) ? 4'b0110 : 4'b0000;
         cyc();
      end
      spike_in = '0;
      repeat (12) cyc();
      fair_on = 1'b0;
      chk("fair_count", 32'(fires.size() >= 8), 1);
      if (fires.size() > 0) chk("fair_first", 32'(fires[0]), 1);
      for (int i = 1; i < fires.size(); i++)
         chk("fair_alt", 32'(fires[i] != fires[i-1]), 1);
      repeat (4) cyc();
      clr_drop = 1'b1; cyc(); clr_drop = 1'b0;
      chk("clr_drop_a", 32'(drop_cnt), 0);

      // Drop while grants are blocked.
      en = 1'b0;
      spike_in = 4'b0010; cyc();                  // E0
      spike_in = '0; cyc();                       // E1
      spike_in = 4'b0010; cyc();                  // E2
      chk("drop_pend", 32'(pending), 32'h2);
      chk("drop_cnt1", 32'(drop_cnt), 1);
      spike_in = '0; en = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         cyc();
         if (spike_out === 1'b1) begin
            pulses++;
            chk("drop_src", 32'(spike_src), 1);
         end
      end
      chk("drop_pulses", 32'(pulses), 1);
      clr_drop = 1'b1; cyc(); clr_drop = 1'b0;
      chk("clr_drop_b", 32'(drop_cnt), 0);
      repeat (2) cyc();

      // Config change during DELAY is ignored; next spike uses the new value.
      delay_cfg = 2'd3;
      spike_in = 4'b0001; cyc();                  // E0
      spike_in = '0; cyc();                       // E1
      delay_cfg = 2'd0;
      for (int k = 2; k <= 4; k++) begin
         cyc();
         chk("cfg_early", 32'(spike_out), 0);
      end
      cyc();                                      // E5
      chk("cfg_fire_d3", 32'(spike_out), 1);
      cyc(); cyc();                               // E7
      spike_in = 4'b0001; cyc();                  // E0'
      spike_in = '0; cyc();                       // E1'
      chk("cfg_grant_d0", 32'(spike_out), 0);
      cyc();                                      // E2'
      chk("cfg_fire_d0", 32'(spike_out), 1);
      repeat (3) cyc();

      // Asynchronous reset during DELAY.
      delay_cfg = 2'd3;
      spike_in = 4'b0011; cyc();                  // E0
      spike_in = '0; cyc();                       // E1: src1 granted
      spike_in = 4'b0001; cyc();                  // E2: src0 re-spikes while pending
      chk("pre_rst_drop", 32'(drop_cnt), 1);
      chk("pre_rst_busy", 32'(busy), 1);
      spike_in = '0;
      #2 reset = 1'b0;
      #1;
      chk("arst_spike_out", 32'(spike_out), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_pending", 32'(pending), 0);
      chk("arst_drop", 32'(drop_cnt), 0);
      @(posedge clk); @(posedge clk);
      #2 reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (spike_out === 1'b1) pulses++;
      end
      chk("arst_no_pulse", 32'(pulses), 0);
      spike_in = 4'b1001; cyc();                  // E0
      spike_in = '0; cyc();                       // E1
      chk("arst_first_src", 32'(spike_src), 0);
      chk("arst_first_busy", 32'(busy), 1);
      repeat (16) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
